// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage registered execute wrapper around a combinational ALU.
// S1 holds the operand bundle and drives the ALU. S2 captures the ALU result
// and presents it downstream over a valid/ready handshake.
// Optional feature macro: EXEC_STATS_EN adds the saturating retire counters
// stat_ops and stat_zeros.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
`ifdef EXEC_STATS_EN
    output logic             out_zero,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_zeros
`else
    output logic             out_zero
`endif
);

    logic             s1_valid_q, s1_valid_d;
    logic [OPW-1:0]   s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_zero_q, out_zero_d;

    logic s2_free;
    logic s1_adv;
    logic accept;
    logic retire;

    // Handshake decode: S2 frees when empty or draining, S1 moves when S2 frees.
    always_comb begin
        s2_free  = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !flush && (!s1_valid_q || s2_free);
        accept   = in_valid && in_ready;
        retire   = s2_valid_q && out_ready;
    end

    // Next-state for both stages; flush only clears the valids, data holds.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s2_valid_d   = s2_valid_q;
        out_result_d = out_result_q;
        out_zero_d   = out_zero_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
                s1_op_d    = in_op;
                s1_a_d     = in_a;
                s1_b_d     = in_b;
            end else if (s1_adv) begin
                s1_valid_d = 1'b0;
            end
            if (s1_adv) begin
                s2_valid_d   = 1'b1;
                out_result_d = alu_result;
                out_zero_d   = alu_zero;
            end else if (retire) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    // Pipeline registers for S1 (operands) and S2 (result).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s2_valid_q   <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s2_valid_q   <= s2_valid_d;
            out_result_q <= out_result_d;
            out_zero_q   <= out_zero_d;
        end
    end

    assign alu_op     = s1_op_q;
    assign alu_a      = s1_a_q;
    assign alu_b      = s1_b_q;
    assign out_valid  = s2_valid_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;

`ifdef EXEC_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_zeros_q, stat_zeros_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Retire counters advance on every output handshake; flush leaves them alone.
    always_comb begin
        stat_ops_d   = stat_ops_q;
        stat_zeros_d = stat_zeros_q;
        if (retire) begin
            stat_ops_d = sat_inc(stat_ops_q);
            if (out_zero_q) begin
                stat_zeros_d = sat_inc(stat_zeros_q);
            end
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q   <= '0;
            stat_zeros_q <= '0;
        end else begin
            stat_ops_q   <= stat_ops_d;
            stat_zeros_q <= stat_zeros_d;
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_zeros = stat_zeros_q;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: a behavioural ALU stands in for the real alu,
// and a queue-based reference model predicts handshakes and retired results.
module tb_alu_exec_stage;

    localparam int W   = 32;
    localparam int OPW = 4;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [W-1:0]   in_a, in_b;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_a, alu_b;
    logic [W-1:0]   alu_result;
    logic           alu_zero;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_result;
    logic           out_zero;
`ifdef EXEC_STATS_EN
    logic [15:0]    stat_ops, stat_zeros;
`endif

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(W), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result),
`ifdef EXEC_STATS_EN
        .out_zero(out_zero), .stat_ops(stat_ops), .stat_zeros(stat_zeros)
`else
        .out_zero(out_zero)
`endif
    );

    // Behavioural ALU. Op 5 passes a through and flags equality, so its zero
    // flag is deliberately not (result == 0).
    function automatic logic [W:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic z;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a;
            default: r = '0;
        endcase
        z = (op == 4'd5) ? (a == b) : (r == '0);
        return {z, r};
    endfunction

    always_comb {alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        bit           in_s2;
    } ent_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   vcount = 0;
    int   rcount = 0;
    int   m_ops = 0;
    int   m_zeros = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model across the rising edge.
    task automatic cycle(input bit v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit rdy, input bit fl, output bit acc);
        bit   pr, ov;
        ent_t e;
        logic [W:0] f;
        in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = rdy; flush = fl;
        #1;
        pr = !fl && (q.size() < 2 || rdy);
        ov = (q.size() > 0) && q[0].in_s2;
        chk("in_ready", W'(in_ready), W'(pr));
        chk("out_valid", W'(out_valid), W'(ov));
        if (out_valid === 1'b1) vcount++;
        if (ov) begin
            chk("out_result", out_result, q[0].r);
            chk("out_zero", W'(out_zero), W'(q[0].z));
        end
        acc = v && pr;
        @(posedge clk);
        if (ov && rdy) begin
            if (m_ops < 16'hFFFF) m_ops++;
            if (q[0].z && m_zeros < 16'hFFFF) m_zeros++;
            rcount++;
        end
        if (fl) begin
            q.delete();
        end else begin
            if (ov && rdy) void'(q.pop_front());
            if (q.size() > 0 && !q[0].in_s2) q[0].in_s2 = 1'b1;
            if (acc) begin
                f = alu_f(op, a, b);
                e.r = f[W-1:0]; e.z = f[W]; e.in_s2 = 1'b0;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy, input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, '0, '0, rdy, 1'b0, acc);
    endtask

    initial begin
        bit acc;
        logic [W-1:0] r0, ra, rb;
        logic [W:0] fa;
        int rc0;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", W'(in_ready), 1);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_zero", W'(out_zero), 0);
        chk("rst_alu_op", W'(alu_op), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
`ifdef EXEC_STATS_EN
        chk("rst_stat_ops", W'(stat_ops), 0);
        chk("rst_stat_zeros", W'(stat_zeros), 0);
`endif
        rst_n = 1'b1;

        // Single op: add 5+3, visible after the second edge, gone one cycle later
        cycle(1'b1, OP_ADD, 32'd5, 32'd3, 1'b1, 1'b0, acc);
        chk("single_acc", W'(acc), 1);
        chk("single_s1_only", W'(out_valid), 0);
        idle(1'b1, 1);
        chk("single_valid", W'(out_valid), 1);
        chk("single_result", out_result, 32'd8);
        chk("single_zero", W'(out_zero), 0);
        idle(1'b1, 1);
        chk("single_gone", W'(out_valid), 0);

        // Streaming: 10 back-to-back ops, the fifth is sub 7-7
        idle(1'b1, 1);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) cycle(1'b1, OP_SUB, 32'd7, 32'd7, 1'b1, 1'b0, acc);
            else cycle(1'b1, 4'($urandom_range(0, 5)), $urandom, $urandom, 1'b1, 1'b0, acc);
            chk("stream_acc", W'(acc), 1);
        end
        idle(1'b1, 2);
        chk("stream_valids", W'(vcount), 10);
`ifdef EXEC_STATS_EN
        chk("stream_stat_ops", W'(stat_ops), W'(m_ops));
        chk("stream_stat_zeros", W'(stat_zeros), W'(m_zeros));
`endif

        // Back-pressure: two accepted, third stalls, first result holds
        fa = alu_f(OP_ADD, 32'd100, 32'd23);
        ra = fa[W-1:0];
        cycle(1'b1, OP_ADD, 32'd100, 32'd23, 1'b0, 1'b0, acc);
        chk("bp_acc0", W'(acc), 1);
        cycle(1'b1, 4'd4, 32'hF0F0, 32'h0FF0, 1'b0, 1'b0, acc);
        chk("bp_acc1", W'(acc), 1);
        r0 = out_result;
        chk("bp_first_result", r0, ra);
        rc0 = rcount;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, OP_SUB, 32'd9, 32'd2, 1'b0, 1'b0, acc);
            chk("bp_stall", W'(acc), 0);
            chk("bp_stable", out_result, r0);
        end
        cycle(1'b1, OP_SUB, 32'd9, 32'd2, 1'b1, 1'b0, acc);
        chk("bp_release_acc", W'(acc), 1);
        idle(1'b1, 3);
        rb = W'(rcount - rc0);
        chk("bp_retired", rb, 3);

        // Flush with both stages full and a valid input present
        cycle(1'b1, OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0, acc);
        cycle(1'b1, OP_ADD, 32'd3, 32'd4, 1'b0, 1'b0, acc);
        cycle(1'b1, OP_ADD, 32'd5, 32'd6, 1'b0, 1'b1, acc);
        chk("flush_no_acc", W'(acc), 0);
        chk("flush_out_valid", W'(out_valid), 0);
`ifdef EXEC_STATS_EN
        chk("flush_stat_keep", W'(stat_ops), W'(m_ops));
`endif
        cycle(1'b1, OP_ADD, 32'd20, 32'd22, 1'b1, 1'b0, acc);
        idle(1'b1, 1);
        chk("post_flush_result", out_result, 32'd42);
        idle(1'b1, 1);

        // Asynchronous reset between edges, mid-stream
        cycle(1'b1, OP_ADD, 32'd11, 32'd12, 1'b1, 1'b0, acc);
        cycle(1'b1, OP_ADD, 32'd13, 32'd14, 1'b1, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", W'(out_valid), 0);
        chk("arst_alu_a", alu_a, 0);
`ifdef EXEC_STATS_EN
        chk("arst_stat_ops", W'(stat_ops), 0);
`endif
        q.delete(); m_ops = 0; m_zeros = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, 1'b0, acc);
        chk("arst_first_acc", W'(acc), 1);
        idle(1'b1, 1);
        chk("arst_result", out_result, 32'd2);
        idle(1'b1, 1);

        // Randomised traffic with random back-pressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 5)),
                  (($urandom_range(0, 3) == 0) ? 32'd6 : $urandom), (($urandom_range(0, 3) == 0) ? 32'd6 : $urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0), acc);
        end
        idle(1'b1, 3);
`ifdef EXEC_STATS_EN
        chk("rand_stat_ops", W'(stat_ops), W'(m_ops));
        chk("rand_stat_zeros", W'(stat_zeros), W'(m_zeros));

        // Saturation: 70000 zero-result retires
        for (int i = 0; i < 70000; i++) begin
            cycle(1'b1, OP_SUB, 32'd3, 32'd3, 1'b1, 1'b0, acc);
        end
        idle(1'b1, 2);
        chk("sat_stat_ops", W'(stat_ops), 32'h0000FFFF);
        chk("sat_stat_zeros", W'(stat_zeros), 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
